stack_seq_ctrl: RTL and testbench

Multicycle sequencer for the 8-bit stack processor datapath. It decodes the 3-bit opcode and steps the datapath through fetch, decode and per-instruction execute states by driving the datapath's strobe and select lines. It stretches every memory access until a `mem_ready` handshake arrives. It sits beside the datapath in the processor top and replaces free-running fixed-latency sequencing, so memories with wait states can be attached.

---
 rtl/stack_ctrl_pkg.sv | 38 +++
 rtl/stack_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared encodings for the stack processor sequencer
// Purpose: opcode enum, sequencer state enum and ALU command constants.
// Ports: none (package).
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_POP_A    = 4'd2,
    ST_POP_B    = 4'd3,
    ST_ALU_PUSH = 4'd4,
    ST_NOT_PUSH = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_PUSH_WR  = 4'd7,
    ST_POP_RD   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_JMP      = 4'd10,
    ST_TOS_RD   = 4'd11,
    ST_JZ_BR    = 4'd12
  } state_e;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_AND = 2'b10;
  localparam logic [1:0] CMD_NOT = 2'b11;

endpackage

// File: rtl/stack_seq_ctrl.sv
// rtl/stack_seq_ctrl.sv - multicycle sequencer with mem_ready handshake
// Purpose: steps the stack datapath through fetch, decode and execute states,
//   holding memory states until mem_ready.
// Ports: clk, rst (async, active-low); opcode = IR[7:5]; mem_ready handshake;
//   outputs are datapath strobes/selects plus instr_done pulse.
module stack_seq_ctrl
  import stack_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       IorD,
  output logic       IR_write,
  output logic       Pc_src,
  output logic       readmem,
  output logic       writemem,
  output logic       MtoS,
  output logic       ld_A,
  output logic       ld_B,
  output logic       pop,
  output logic       push,
  output logic       tos,
  output logic       Sel_A,
  output logic       Sel_B,
  output logic [1:0] controller_command,
  output logic       instr_done
);

  state_e  r_state;
  state_e  w_next;
  opcode_e w_op;
  logic    w_pcw, w_pcwc, w_iord, w_irw, w_pcsrc, w_rd, w_wr, w_mtos;
  logic    w_lda, w_ldb, w_pop, w_push, w_tos, w_sela, w_selb, w_done;
  logic [1:0] w_cmd;

  assign w_op = opcode_e'(opcode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pcw = 1'b0; w_pcwc = 1'b0; w_iord = 1'b0; w_irw = 1'b0;
    w_pcsrc = 1'b0; w_rd = 1'b0; w_wr = 1'b0; w_mtos = 1'b0;
    w_lda = 1'b0; w_ldb = 1'b0; w_pop = 1'b0; w_push = 1'b0;
    w_tos = 1'b0; w_sela = 1'b0; w_selb = 1'b0; w_done = 1'b0;
    w_cmd = CMD_ADD;
    case (r_state)
      ST_FETCH: begin
        w_rd = 1'b1;
        // IR load and PC+1 fire only in the ready cycle so a wait never repeats them
        if (mem_ready) begin
          w_irw = 1'b1; w_pcw = 1'b1; w_sela = 1'b1; w_selb = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_op)
          OP_PUSH: w_next = ST_MEM_RD;
          OP_POP:  w_next = ST_POP_RD;
          OP_JMP:  w_next = ST_JMP;
          OP_JZ:   w_next = ST_TOS_RD;
          default: w_next = ST_POP_A;
        endcase
      end
      ST_POP_A: begin
        w_pop = 1'b1; w_lda = 1'b1;
        w_next = (w_op == OP_NOT) ? ST_NOT_PUSH : ST_POP_B;
      end
      ST_POP_B: begin
        w_pop = 1'b1; w_ldb = 1'b1;
        w_next = ST_ALU_PUSH;
      end
      ST_ALU_PUSH: begin
        w_push = 1'b1; w_cmd = opcode[1:0]; w_done = 1'b1;
        w_next = ST_FETCH;
      end
      ST_NOT_PUSH: begin
        w_push = 1'b1; w_cmd = CMD_NOT; w_done = 1'b1;
        w_next = ST_FETCH;
      end
      ST_MEM_RD: begin
        w_rd = 1'b1; w_iord = 1'b1;
        if (mem_ready) w_next = ST_PUSH_WR;
      end
      ST_PUSH_WR: begin
        w_push = 1'b1; w_mtos = 1'b1; w_done = 1'b1;
        w_next = ST_FETCH;
      end
      ST_POP_RD: begin
        w_pop = 1'b1; w_lda = 1'b1;
        w_next = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        w_wr = 1'b1; w_iord = 1'b1;
        if (mem_ready) begin
          w_done = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_JMP: begin
        w_pcw = 1'b1; w_pcsrc = 1'b1; w_done = 1'b1;
        w_next = ST_FETCH;
      end
      ST_TOS_RD: begin
        w_tos = 1'b1; w_lda = 1'b1;
        w_next = ST_JZ_BR;
      end
      ST_JZ_BR: begin
        w_pcwc = 1'b1; w_pcsrc = 1'b1; w_done = 1'b1;
        w_next = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // Reset masks the decoded FETCH outputs so the datapath sees all-zero while held
  assign pc_write           = rst & w_pcw;
  assign pc_write_cond      = rst & w_pcwc;
  assign IorD               = rst & w_iord;
  assign IR_write           = rst & w_irw;
  assign Pc_src             = rst & w_pcsrc;
  assign readmem            = rst & w_rd;
  assign writemem           = rst & w_wr;
  assign MtoS               = rst & w_mtos;
  assign ld_A               = rst & w_lda;
  assign ld_B               = rst & w_ldb;
  assign pop                = rst & w_pop;
  assign push               = rst & w_push;
  assign tos                = rst & w_tos;
  assign Sel_A              = rst & w_sela;
  assign Sel_B              = rst & w_selb;
  assign controller_command = rst ? w_cmd : 2'b00;
  assign instr_done         = rst & w_done;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// tb/tb_stack_seq_ctrl.sv - randomized trace-model bench for stack_seq_ctrl
module tb_stack_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, IorD, IR_write, Pc_src, readmem, writemem;
  logic       MtoS, ld_A, ld_B, pop, push, tos, Sel_A, Sel_B, instr_done;
  logic [1:0] controller_command;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [17:0] PCW   = 18'h1 << 17;
  localparam logic [17:0] PCWC  = 18'h1 << 16;
  localparam logic [17:0] IORD  = 18'h1 << 15;
  localparam logic [17:0] IRW   = 18'h1 << 14;
  localparam logic [17:0] PCSRC = 18'h1 << 13;
  localparam logic [17:0] RD    = 18'h1 << 12;
  localparam logic [17:0] WR    = 18'h1 << 11;
  localparam logic [17:0] MTOS  = 18'h1 << 10;
  localparam logic [17:0] LDA   = 18'h1 << 9;
  localparam logic [17:0] LDB   = 18'h1 << 8;
  localparam logic [17:0] POP   = 18'h1 << 7;
  localparam logic [17:0] PUSH  = 18'h1 << 6;
  localparam logic [17:0] TOS   = 18'h1 << 5;
  localparam logic [17:0] SELA  = 18'h1 << 4;
  localparam logic [17:0] SELB  = 18'h1 << 3;
  localparam logic [17:0] DONE  = 18'h1;

  stack_seq_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .IorD(IorD),
    .IR_write(IR_write), .Pc_src(Pc_src), .readmem(readmem), .writemem(writemem),
    .MtoS(MtoS), .ld_A(ld_A), .ld_B(ld_B), .pop(pop), .push(push), .tos(tos),
    .Sel_A(Sel_A), .Sel_B(Sel_B), .controller_command(controller_command),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {pc_write, pc_write_cond, IorD, IR_write, Pc_src, readmem, writemem,
            MtoS, ld_A, ld_B, pop, push, tos, Sel_A, Sel_B, controller_command,
            instr_done};
  endfunction

  function automatic logic [17:0] cmd(input logic [1:0] c);
    return {15'd0, c, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready after the edge, compare on the falling edge
  task automatic step(input logic mr, input logic [17:0] exp, input string tag);
    mem_ready = mr;
    @(negedge clk);
    check(tag, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: an instruction is a fetch (with wait cycles), a
  // decode, then the micro-operations its opcode implies.
  task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
    logic [1:0] q_mr[$];
    logic [17:0] q_ex[$];
    opcode = op;
    for (int i = 0; i < fw; i++) begin q_mr.push_back(0); q_ex.push_back(RD); end
    q_mr.push_back(1); q_ex.push_back(RD | IRW | PCW | SELA | SELB);
    q_mr.push_back(2); q_ex.push_back(18'd0);
    case (op)
      3'b000, 3'b001, 3'b010: begin
        q_mr.push_back(2); q_ex.push_back(POP | LDA);
        q_mr.push_back(2); q_ex.push_back(POP | LDB);
        q_mr.push_back(2); q_ex.push_back(PUSH | DONE | cmd(op[1:0]));
      end
      3'b011: begin
        q_mr.push_back(2); q_ex.push_back(POP | LDA);
        q_mr.push_back(2); q_ex.push_back(PUSH | DONE | cmd(2'b11));
      end
      3'b100: begin
        for (int i = 0; i < mw; i++) begin q_mr.push_back(0); q_ex.push_back(RD | IORD); end
        q_mr.push_back(1); q_ex.push_back(RD | IORD);
        q_mr.push_back(2); q_ex.push_back(PUSH | MTOS | DONE);
      end
      3'b101: begin
        q_mr.push_back(2); q_ex.push_back(POP | LDA);
        for (int i = 0; i < mw; i++) begin q_mr.push_back(0); q_ex.push_back(WR | IORD); end
        q_mr.push_back(1); q_ex.push_back(WR | IORD | DONE);
      end
      3'b110: begin
        q_mr.push_back(2); q_ex.push_back(PCW | PCSRC | DONE);
      end
      default: begin
        q_mr.push_back(2); q_ex.push_back(TOS | LDA);
        q_mr.push_back(2); q_ex.push_back(PCWC | PCSRC | DONE);
      end
    endcase
    // code 2 = don't-care handshake: randomize to show it is ignored
    for (int i = 0; i < q_ex.size(); i++)
      step(q_mr[i] == 2 ? 1'($urandom_range(0, 1)) : q_mr[i][0], q_ex[i],
           $sformatf("op%0d_c%0d", op, i));
  endtask

  initial begin
    // Held in reset: all outputs zero
    @(posedge clk); #1;
    step(1'b1, 18'd0, "reset_hold");
    rst = 1'b1;
    step(1'b0, RD, "first_fetch");
    // Abort a PUSH in the middle of MEM_RD
    opcode = 3'b100;
    step(1'b1, RD | IRW | PCW | SELA | SELB, "abort_fetch");
    step(1'b0, 18'd0, "abort_decode");
    step(1'b0, RD | IORD, "abort_memrd");
    mem_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 18'd0, "reset_mid_memrd");
    rst = 1'b1;
    step(1'b0, RD, "post_reset_fetch");
    step(1'b1, RD | IRW | PCW | SELA | SELB, "post_reset_ready");
    step(1'b0, 18'd0, "post_reset_decode");
    step(1'b1, RD | IORD, "post_reset_memrd");
    step(1'b0, PUSH | MTOS | DONE, "post_reset_pushwr");

    // Directed cases
    run_instr(3'b000, 0, 0);
    run_instr(3'b100, 0, 2);
    run_instr(3'b101, 0, 4);
    run_instr(3'b111, 0, 0);
    run_instr(3'b110, 3, 0);
    run_instr(3'b011, 1, 0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++)
      run_instr(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
